muldiv_unit: RTL and testbench
==============================

MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset; the ports are named clk and reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  synchronous, active-high; takes effect at a clk rising edge.
REQ-004 start  input  1  request to begin the operation selected by op; sampled only while idle.
REQ-005 op  input  2  operation select: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-006 a  input  32  multiplicand or dividend (rs value from the datapath).
REQ-007 b  input  32  multiplier or divisor (rt value from the datapath).
REQ-008 wrhi  input  1  MTHI: write wrdata to HI.
REQ-009 wrlo  input  1  MTLO: write wrdata to LO.
REQ-010 wrdata  input  32  data for MTHI/MTLO.
REQ-011 hi  output  32  HI register (MFHI source).
REQ-012 lo  output  32  LO register (MFLO source).
REQ-013 busy  output  1  high while an operation is in progress; the decoder stalls the PC while busy is high.
REQ-014 done  output  1  one-cycle pulse when HI/LO receive a new result.

Function
REQ-015 SHALL implement two states, IDLE and RUN, with a 5-bit iteration counter.
REQ-016 IDLE with start=1 at edge E0: latch a, b and op; enter RUN with counter=0; busy=1 from E0.
REQ-017 RUN: perform one iteration per edge (one shift-add bit for multiply, one restoring-subtract bit for divide); 32 iterations, at edges E1..E32.
REQ-018 At E32: write the results to hi/lo, return to IDLE, set busy=0, and set done=1 for exactly the one cycle after E32.
REQ-019 Latency from the start edge to the result edge SHALL be fixed at 32 cycles for every op, including divide-by-zero.
REQ-020 MULT/MULTU: form the full 64-bit product; hi=product[63:32], lo=product[31:0]. MULT is two's complement; MULTU is unsigned.
REQ-021 Signed ops: compute on operand magnitudes, then negate the result as required; add no extra cycles.
REQ-022 DIV: quotient truncates toward zero and goes to lo; remainder takes the sign of the dividend and goes to hi.
REQ-023 DIVU: unsigned quotient to lo, unsigned remainder to hi.
REQ-024 Divide by zero (DIV or DIVU): hi=a, lo=0xFFFFFFFF.
REQ-025 DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0x00000000; no trap.
REQ-026 start while in RUN: ignored; the operation in progress is unaffected.
REQ-027 wrhi/wrlo in IDLE: the selected register is written at the next edge; both may be written in the same cycle.
REQ-028 wrhi/wrlo in RUN: ignored.
REQ-029 wrhi/wrlo together with start in IDLE: the writes apply at E0, and the operation is also accepted.
REQ-030 hi/lo SHALL hold their values at all times except at reset, a completion edge, or an accepted MTHI/MTLO write.
REQ-031 Operands are latched at E0; changes on a/b/op during RUN SHALL NOT affect the result.

Reset
REQ-032 reset=1 at an edge forces: state=IDLE, counter=0, hi=0, lo=0, busy=0, done=0.
REQ-033 reset during RUN abandons the operation: no done pulse, no partial result visible on hi/lo.
REQ-034 reset has priority over start, wrhi and wrlo in the same cycle.

Verification
REQ-035 MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> busy high for 32 cycles; done pulse once; hi=0xFFFFFFFE, lo=0x00000001.
REQ-036 MULT a=0xFFFFFFFD (-3) b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB.
REQ-037 DIV a=0xFFFFFFF9 (-7) b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. Then DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-038 DIVU a=100 b=0 -> after 32 cycles hi=0x00000064, lo=0xFFFFFFFF.
REQ-039 Start/write while busy:
  - Start MULTU 5*6; assert start with different operands at cycle 5; pulse wrhi (wrdata=0xDEADBEEF) at cycle 10.
  - Required: hi=0, lo=30; exactly one done pulse.
  - Then in IDLE pulse wrlo=0x12345678 -> lo=0x12345678 next cycle.
REQ-040 Reset mid-operation: start DIVU 1000/7, assert reset at cycle 10 -> next cycle busy=0, hi=0, lo=0; done never pulses; a following DIVU 1000/7 -> lo=142, hi=6.

Source files
------------

// File: rtl/muldiv_if.sv
// muldiv_if: request/result bundle between the instruction datapath and
// the multiply/divide unit.
//   start, op[1:0], a[31:0], b[31:0]  operation request (master -> slave)
//   wrhi, wrlo, wrdata[31:0]          MTHI/MTLO writes  (master -> slave)
//   hi[31:0], lo[31:0]                result registers  (slave -> master)
//   busy, done                        status            (slave -> master)
interface muldiv_if;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        wrhi;
  logic        wrlo;
  logic [31:0] wrdata;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;

  modport master (
    output start, op, a, b, wrhi, wrlo, wrdata,
    input  hi, lo, busy, done
  );

  modport slave (
    input  start, op, a, b, wrhi, wrlo, wrdata,
    output hi, lo, busy, done
  );
endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative 32x32 multiply / 32/32 divide with HI/LO registers.
// Every operation takes exactly 32 iterations after the start edge.
//   clk    rising-edge clock
//   reset  synchronous, active-high
//   bus    muldiv_if.slave: start/op/a/b request, wrhi/wrlo/wrdata MTHI/MTLO,
//          hi/lo results, busy status, done one-cycle completion pulse
//
// state  | meaning
// S_IDLE | waiting; accepts start and MTHI/MTLO writes
// S_RUN  | iterating, one bit per edge, cnt_q = iterations already done
module muldiv_unit (
  input  logic     clk,
  input  logic     reset,
  muldiv_if.slave  bus
);

  typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        is_div_q, is_div_d;
  logic        neg_a_q, neg_a_d;
  logic        neg_b_q, neg_b_d;
  logic        bzero_q, bzero_d;
  logic [31:0] opb_q, opb_d;
  logic [31:0] acc_hi_q, acc_hi_d;
  logic [31:0] acc_lo_q, acc_lo_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        done_q, done_d;

  // operand magnitudes at start (signed ops only)
  logic        in_signed;
  logic [31:0] a_mag, b_mag;
  // one iteration of each algorithm
  logic [32:0] mul_sum;
  logic [31:0] mul_hi, mul_lo;
  logic [32:0] div_shift;
  logic [33:0] div_diff;
  logic [31:0] div_hi, div_lo;
  // final sign fix-up
  logic [63:0] prod_mag, prod_res;
  logic [31:0] quo_res, rem_res, res_hi, res_lo;

  always_comb begin
    in_signed = ~bus.op[0];
    a_mag     = (in_signed && bus.a[31]) ? (~bus.a + 32'd1) : bus.a;
    b_mag     = (in_signed && bus.b[31]) ? (~bus.b + 32'd1) : bus.b;

    // shift-add: multiplier occupies acc_lo and is consumed from the LSB
    // while the product grows into acc_hi and shifts down into acc_lo
    mul_sum = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opb_q} : 33'd0);
    mul_hi  = mul_sum[32:1];
    mul_lo  = {mul_sum[0], acc_lo_q[31:1]};

    // restoring divide: acc_hi is the partial remainder, acc_lo shifts the
    // dividend out at the top and the quotient bits in at the bottom
    div_shift = {acc_hi_q, acc_lo_q[31]};
    div_diff  = {1'b0, div_shift} - {2'b00, opb_q};
    if (!div_diff[33]) begin
      div_hi = div_diff[31:0];
      div_lo = {acc_lo_q[30:0], 1'b1};
    end else begin
      div_hi = div_shift[31:0];
      div_lo = {acc_lo_q[30:0], 1'b0};
    end

    prod_mag = {mul_hi, mul_lo};
    prod_res = (neg_a_q ^ neg_b_q) ? (~prod_mag + 64'd1) : prod_mag;
    quo_res  = (neg_a_q ^ neg_b_q) ? (~div_lo + 32'd1) : div_lo;
    // remainder follows the dividend's sign; with b=0 this restores a exactly
    rem_res  = neg_a_q ? (~div_hi + 32'd1) : div_hi;

    res_hi = is_div_q ? rem_res : prod_res[63:32];
    res_lo = is_div_q ? (bzero_q ? 32'hFFFF_FFFF : quo_res) : prod_res[31:0];
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    is_div_d = is_div_q;
    neg_a_d  = neg_a_q;
    neg_b_d  = neg_b_q;
    bzero_d  = bzero_q;
    opb_d    = opb_q;
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.wrhi) hi_d = bus.wrdata;
        if (bus.wrlo) lo_d = bus.wrdata;
        if (bus.start) begin
          state_d  = S_RUN;
          cnt_d    = 5'd0;
          is_div_d = bus.op[1];
          neg_a_d  = in_signed & bus.a[31];
          neg_b_d  = in_signed & bus.b[31];
          bzero_d  = (bus.b == 32'd0);
          acc_hi_d = 32'd0;
          acc_lo_d = bus.op[1] ? a_mag : b_mag;
          opb_d    = bus.op[1] ? b_mag : a_mag;
        end
      end
      S_RUN: begin
        cnt_d    = cnt_q + 5'd1;
        acc_hi_d = is_div_q ? div_hi : mul_hi;
        acc_lo_d = is_div_q ? div_lo : mul_lo;
        if (cnt_q == 5'd31) begin
          state_d = S_IDLE;
          hi_d    = res_hi;
          lo_d    = res_lo;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= 5'd0;
      is_div_q <= 1'b0;
      neg_a_q  <= 1'b0;
      neg_b_q  <= 1'b0;
      bzero_q  <= 1'b0;
      opb_q    <= 32'd0;
      acc_hi_q <= 32'd0;
      acc_lo_q <= 32'd0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      is_div_q <= is_div_d;
      neg_a_q  <= neg_a_d;
      neg_b_q  <= neg_b_d;
      bzero_q  <= bzero_d;
      opb_q    <= opb_d;
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
    end
  end

  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;
  assign bus.busy = (state_q == S_RUN);
  assign bus.done = done_q;

endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  muldiv_if bus();

  muldiv_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // reference: plain 64-bit arithmetic, returns {hi, lo}
  function automatic logic [63:0] ref_op(input logic [1:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
    longint          sp;
    longint unsigned up;
    int              sa, sb, q, r;
    logic [63:0]     res;
    sa = int'(a);
    sb = int'(b);
    case (op)
      2'b00: begin
        sp  = longint'(sa) * longint'(sb);
        res = 64'(sp);
      end
      2'b01: begin
        up  = longint'({32'd0, a}) * longint'({32'd0, b});
        res = 64'(up);
      end
      2'b10: begin
        if (b == 32'd0) res = {a, 32'hFFFF_FFFF};
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) res = {32'd0, 32'h8000_0000};
        else begin
          q   = sa / sb;
          r   = sa % sb;
          res = {32'(r), 32'(q)};
        end
      end
      default: begin
        if (b == 32'd0) res = {a, 32'hFFFF_FFFF};
        else res = {a % b, a / b};
      end
    endcase
    return res;
  endfunction

  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input string tag);
    logic [63:0] exp;
    int cyc;
    int dones;
    exp = ref_op(op, a, b);
    @(negedge clk);
    bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.a = $urandom; bus.b = $urandom; bus.op = 2'($urandom);
    check({tag, "_busy_e0"}, 32'(bus.busy), 32'd1);
    cyc = 0; dones = 0;
    while (bus.busy && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
      if (bus.done) dones++;
    end
    check({tag, "_latency"}, 32'(cyc), 32'd32);
    check({tag, "_done"}, 32'(bus.done), 32'd1);
    check({tag, "_hi"}, bus.hi, exp[63:32]);
    check({tag, "_lo"}, bus.lo, exp[31:0]);
    @(posedge clk); #1;
    check({tag, "_done_drop"}, 32'(bus.done), 32'd0);
    check({tag, "_done_count"}, 32'(dones), 32'd1);
  endtask

  initial begin
    int dones;
    int cyc;
    logic [1:0]  rop;
    logic [31:0] ra, rb;
    total = 0; bad = 0;
    reset = 1'b1;
    bus.start = 1'b0; bus.op = 2'b00; bus.a = '0; bus.b = '0;
    bus.wrhi = 1'b0; bus.wrlo = 1'b0; bus.wrdata = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_hi", bus.hi, 32'd0);
    check("rst_lo", bus.lo, 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max");
    check("multu_max_hi_const", bus.hi, 32'hFFFF_FFFE);
    check("multu_max_lo_const", bus.lo, 32'h0000_0001);
    run_op(2'b00, 32'hFFFF_FFFD, 32'd7, "mult_neg");
    check("mult_neg_lo_const", bus.lo, 32'hFFFF_FFEB);
    run_op(2'b10, 32'hFFFF_FFF9, 32'd2, "div_neg");
    check("div_neg_lo_const", bus.lo, 32'hFFFF_FFFD);
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
    run_op(2'b11, 32'd100, 32'd0, "divu_zero");
    check("divu_zero_hi_const", bus.hi, 32'h0000_0064);
    run_op(2'b10, 32'hFFFF_FF00, 32'd0, "div_zero_neg");
    run_op(2'b00, 32'h8000_0000, 32'h8000_0000, "mult_minmin");

    // start and MTHI while busy are ignored
    @(negedge clk);
    bus.start = 1'b1; bus.op = 2'b01; bus.a = 32'd5; bus.b = 32'd6;
    @(posedge clk); #1;
    dones = 0;
    for (int c = 1; c <= 40; c++) begin
      bus.start  = (c == 5);
      bus.op     = 2'b10; bus.a = 32'd99; bus.b = 32'd4;
      bus.wrhi   = (c == 10);
      bus.wrdata = 32'hDEAD_BEEF;
      @(posedge clk); #1;
      if (bus.done) dones++;
    end
    bus.start = 1'b0; bus.wrhi = 1'b0;
    check("busy_ign_hi", bus.hi, 32'd0);
    check("busy_ign_lo", bus.lo, 32'd30);
    check("busy_ign_dones", 32'(dones), 32'd1);
    check("busy_ign_idle", 32'(bus.busy), 32'd0);

    @(negedge clk);
    bus.wrlo = 1'b1; bus.wrdata = 32'h1234_5678;
    @(posedge clk); #1;
    bus.wrlo = 1'b0;
    check("mtlo_lo", bus.lo, 32'h1234_5678);
    check("mtlo_hi_kept", bus.hi, 32'd0);

    @(negedge clk);
    bus.wrhi = 1'b1; bus.wrdata = 32'hCAFE_0001;
    @(posedge clk); #1;
    bus.wrhi = 1'b0;
    check("mthi_hi", bus.hi, 32'hCAFE_0001);
    check("mthi_lo_kept", bus.lo, 32'h1234_5678);

    // reset mid-operation
    @(negedge clk);
    bus.start = 1'b1; bus.op = 2'b11; bus.a = 32'd1000; bus.b = 32'd7;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("midrst_busy", 32'(bus.busy), 32'd0);
    check("midrst_hi", bus.hi, 32'd0);
    check("midrst_lo", bus.lo, 32'd0);
    dones = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (bus.done) dones++;
    end
    check("midrst_no_done", 32'(dones), 32'd0);
    check("midrst_lo_held", bus.lo, 32'd0);
    run_op(2'b11, 32'd1000, 32'd7, "divu_after_rst");
    check("divu_after_rst_lo_const", bus.lo, 32'd142);
    check("divu_after_rst_hi_const", bus.hi, 32'd6);

    // MTHI+MTLO together with start: writes land at E0, op still accepted
    @(negedge clk);
    bus.start = 1'b1; bus.op = 2'b01; bus.a = 32'd3; bus.b = 32'd4;
    bus.wrhi = 1'b1; bus.wrlo = 1'b1; bus.wrdata = 32'h55AA_55AA;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.wrhi = 1'b0; bus.wrlo = 1'b0;
    check("wrstart_hi", bus.hi, 32'h55AA_55AA);
    check("wrstart_lo", bus.lo, 32'h55AA_55AA);
    check("wrstart_busy", 32'(bus.busy), 32'd1);
    cyc = 0;
    while (bus.busy && cyc < 40) begin @(posedge clk); #1; cyc++; end
    check("wrstart_latency", 32'(cyc), 32'd32);
    check("wrstart_res_hi", bus.hi, 32'd0);
    check("wrstart_res_lo", bus.lo, 32'd12);

    // randomized operations against the reference
    for (int i = 0; i < 40; i++) begin
      rop = 2'($urandom);
      ra  = $urandom;
      rb  = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: rb = 32'($urandom_range(1, 15));
        2: ra = 32'h8000_0000;
        3: rb = 32'hFFFF_FFFF;
        default: ;
      endcase
      run_op(rop, ra, rb, $sformatf("rand%0d_op%0d", i, rop));
    end

    // reset wins over start and MTHI in the same cycle
    @(negedge clk);
    bus.wrhi = 1'b1; bus.wrdata = 32'hA5A5_A5A5;
    @(posedge clk); #1;
    bus.wrhi = 1'b0;
    check("prio_pre_hi", bus.hi, 32'hA5A5_A5A5);
    @(negedge clk);
    reset = 1'b1; bus.start = 1'b1; bus.op = 2'b01; bus.a = 32'd9; bus.b = 32'd9;
    bus.wrhi = 1'b1; bus.wrlo = 1'b1; bus.wrdata = 32'h1111_2222;
    @(posedge clk); #1;
    reset = 1'b0; bus.start = 1'b0; bus.wrhi = 1'b0; bus.wrlo = 1'b0;
    check("prio_busy", 32'(bus.busy), 32'd0);
    check("prio_hi", bus.hi, 32'd0);
    check("prio_lo", bus.lo, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
